// File: rtl/moving_average_filter_param.sv
// Streaming boxcar averager with a runtime power-of-2 window (N = 2^win_log2, clamped to 2^MAX_WIN_LOG2).
// Define MOVING_AVERAGE_ROUND_EN to round half-up; otherwise the output truncates toward -inf.
module moving_average_filter_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_WIN_LOG2  = 4,
    parameter int WIN_SEL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [WIN_SEL_WIDTH-1:0] win_log2,
    input  logic                     flush,
    output logic                     valid_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     primed
);

    localparam int DEPTH = 1 << MAX_WIN_LOG2;
    localparam int PTR_W = MAX_WIN_LOG2;
    localparam int FW    = MAX_WIN_LOG2 + 1;
    localparam int SW    = DATA_WIDTH + MAX_WIN_LOG2;
    localparam logic [WIN_SEL_WIDTH-1:0] MAX_SEL = WIN_SEL_WIDTH'(MAX_WIN_LOG2);

    logic [WIN_SEL_WIDTH-1:0] win_clamped;
    logic [WIN_SEL_WIDTH-1:0] active_win;
    logic                     win_change;
    logic                     clear;
    logic                     accepted;
    logic [FW-1:0]            n_val;
    logic [FW-1:0]            fill;
    logic [FW-1:0]            fill_next;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0]    sample_buf [DEPTH];
    logic [DATA_WIDTH-1:0]    x_old;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     sum_next;
    logic                     v1;
    logic [DATA_WIDTH-1:0]    avg;

    always_comb begin
        win_clamped = (win_log2 > MAX_SEL) ? MAX_SEL : win_log2;
        win_change  = (win_clamped != active_win);
        clear       = flush | win_change;
        accepted    = valid_in & ~clear;
        n_val       = FW'(1) << active_win;
        // For a full-depth window the low bits of N are zero, so this reads the slot about to be overwritten.
        rd_idx      = wr_ptr - n_val[PTR_W-1:0];
        x_old       = (fill == n_val) ? sample_buf[rd_idx] : '0;
        fill_next   = fill;
        if (accepted && (fill != n_val)) begin
            fill_next = fill + FW'(1);
        end
        sum_next = sum
                 + $signed({{MAX_WIN_LOG2{data_in[DATA_WIDTH-1]}}, data_in})
                 - $signed({{MAX_WIN_LOG2{x_old[DATA_WIDTH-1]}}, x_old});
    end

`ifdef MOVING_AVERAGE_ROUND_EN
    logic signed [SW:0] bias;
    logic signed [SW:0] rounded;

    always_comb begin
        bias    = (active_win == '0) ? '0 : ((SW+1)'(1) << (active_win - WIN_SEL_WIDTH'(1)));
        rounded = $signed({sum[SW-1], sum}) + bias;
        avg     = DATA_WIDTH'(rounded >>> active_win);
    end
`else
    always_comb begin
        avg = DATA_WIDTH'(sum >>> active_win);
    end
`endif

    // Buffer contents need no reset: entries are masked until the window has refilled.
    always_ff @(posedge clk) begin
        if (!rst && accepted) begin
            sample_buf[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            primed     <= 1'b0;
            sum        <= '0;
            fill       <= '0;
            wr_ptr     <= '0;
            v1         <= 1'b0;
            active_win <= win_clamped;
        end else begin
            // Stage 2 sees the pre-clear sum, so an in-flight result survives a flush.
            valid_out <= v1;
            if (v1) begin
                data_out <= avg;
            end
            if (clear) begin
                active_win <= win_clamped;
                sum        <= '0;
                fill       <= '0;
                primed     <= 1'b0;
                v1         <= 1'b0;
            end else begin
                fill   <= fill_next;
                primed <= (fill_next == n_val);
                v1     <= accepted && (fill_next == n_val);
                if (accepted) begin
                    sum    <= sum_next;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/moving_average_filter_param.md
Name: moving_average_filter_param

Overview:
- Streaming boxcar averager for signed samples. Generalises the fixed 4-tap averager to a runtime-selectable power-of-2 window up to 2^MAX_WIN_LOG2 taps.
- Uses a recursive running sum (add newest, subtract oldest) over a circular sample buffer, with full-precision accumulation and a warm-up gate.
- Sits in the readout DSP chain between the demodulator output and the discriminator.

Parameters:
- DATA_WIDTH, 8, signed sample width, in and out.
- MAX_WIN_LOG2, 4, log2 of the largest supported window. Buffer depth is 2^MAX_WIN_LOG2.
- WIN_SEL_WIDTH, 3, width of the win_log2 port. Must satisfy 2^WIN_SEL_WIDTH > MAX_WIN_LOG2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  sample qualifier.
- data_in  in  DATA_WIDTH  signed sample.
- win_log2  in  WIN_SEL_WIDTH  requested window log2 (N = 2^win_log2). Values above MAX_WIN_LOG2 clamp to MAX_WIN_LOG2.
- flush  in  1  restart averaging. Clears sum and fill count.
- valid_out  out  1  average qualifier.
- data_out  out  DATA_WIDTH  signed average.
- primed  out  1  high when fill count has reached N.

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - valid_out=0, data_out=0, primed=0.
  - sum=0, fill=0, wr_ptr=0, stage-1 valid=0.
  - active_win = clamp(win_log2) sampled during reset.
  - Buffer contents are don't-care; masking makes them unobservable.
- Accepted sample: valid_in=1, with no flush and no window change in the same cycle.
  - buf[wr_ptr] <= data_in.
  - wr_ptr <= wr_ptr+1, wrapping modulo 2^MAX_WIN_LOG2.
- Oldest sample x_old = buf[(wr_ptr - N) mod depth], masked to 0 while fill < N.
- Sum register width is DATA_WIDTH+MAX_WIN_LOG2, signed. Update: sum <= sum + sext(data_in) - sext(x_old). It can never overflow.
- Fill counter is MAX_WIN_LOG2+1 bits. It increments per accepted sample and saturates at N. primed = (fill == N), registered.
- Pipeline, latency 2 cycles from accepting valid_in to valid_out:
  - Stage 1: sum update; v1 <= accepted AND (fill_next == N).
  - Stage 2: data_out <= sum >>> active_win (arithmetic shift, truncating toward -inf); valid_out <= v1.
- data_out holds its last value when valid_out=0.
- Warm-up: the first N-1 accepted samples after reset, flush or window change produce no valid_out. The Nth and every later sample each produce exactly one valid_out.
- Bubbles: valid_in=0 cycles do not advance pointer, sum or fill. The window is N accepted samples, not N cycles.
- Window change: when clamp(win_log2) != active_win on a clock edge:
  - active_win updates.
  - Same action as flush: sum<=0, fill<=0, primed<=0, v1<=0.
  - Any valid_in that cycle is discarded.
  - wr_ptr is left unchanged.
- flush: same clear as a window change. It takes priority over valid_in, so a coincident sample is dropped.
  - A result already in stage 2 at the flush edge still emits on the next cycle.
  - No further outputs appear until re-primed.
- rst mid-stream: all state clears on that edge. valid_out=0 from the next cycle.
- N=1 (win_log2=0): pass-through with 2-cycle latency. primed after the first sample.
- Full-depth window (N = depth): x_old is the entry being overwritten, read before write in the same cycle.

Optional Feature:
- Macro: MOVING_AVERAGE_ROUND_EN.
- Defined: output = (sum + 2^(active_win-1)) >>> active_win, i.e. round-half-up. No rounding bias is added when active_win=0. The add uses one extra guard bit, so there is no overflow.
- Undefined: plain arithmetic shift, truncating toward -inf.
- Latency is 2 cycles either way.

Test Plan:
- win_log2=2, rst, then valid_in every cycle with data 4,8,12,16,20 → valid_out first high 2 cycles after the 4th sample with data_out=10, next cycle 14. No valid_out earlier.
- win_log2=3, eight samples of -3 → data_out=-3 without ROUND_EN. Samples -1,-1,0,0,0,0,0,0 (sum -2) → data_out=-1 without ROUND_EN, 0 with ROUND_EN.
- win_log2=2, stream with valid_in toggling 1,0,1,0 using samples 100,100,100,100 → valid_out asserted only after the 4th accepted sample, data_out=100. Output count equals accepted count minus 3.
- Primed at win_log2=2, change win_log2 to 1 while valid_in=1 → coincident sample dropped, primed=0. Next two samples 6,10 → data_out=8.
- flush and valid_in asserted together while primed → sample dropped. An in-flight result emits once, then valid_out stays 0 until 4 new samples.
- win_log2=7 with MAX_WIN_LOG2=4 → behaves as N=16. Constant 127 for 40 samples (wrap exercised) → data_out=127 from the 16th sample. Assert rst mid-stream → valid_out=0 and data_out=0 the next cycle.
